regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the fixed 4+4 register file: N_GP general-purpose registers and N_AR address registers with configurable widths.
- Serves one write port and three read ports (MAIN, LHS, RHS) on the data side.
- Serves one load port, one step port and one read port on the address side.
- New relative to the previous generation: address registers can step by +1 or -1, report wrap-around, and load from a concatenated GP register pair. Sits between the control decoder and the ALU/memory interface.

Parameters:
DATA_W, 8, width of GP registers and the MAIN/LHS/RHS buses
ADDR_W, 16, width of address registers and the ADDR bus; must equal 2*DATA_W when pair-load is used
N_GP, 4, number of GP registers (2..8)
N_AR, 4, number of address registers (1..8)
SEL_W, 3, register select width; must satisfy 2**SEL_W >= max(N_GP, N_AR)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_bar  in  1  synchronous active-low reset
MAIN_LOAD_bar  in  1  write enable for GP[MAIN_LOAD_SEL]
MAIN_LOAD_SEL  in  SEL_W  GP write select
MAIN_in  in  DATA_W  GP write data
MAIN_ASSERT_bar  in  1  MAIN read enable
MAIN_ASSERT_SEL  in  SEL_W  MAIN read select
MAIN_out  out  DATA_W  MAIN read data
MAIN_OE  out  1  MAIN_out valid/drive
LHS_ASSERT_bar, RHS_ASSERT_bar  in  1 each  LHS/RHS read enables
LHS_ASSERT_SEL, RHS_ASSERT_SEL  in  SEL_W each  LHS/RHS read selects
LHS_out, RHS_out  out  DATA_W each  ALU operand data
LHS_OE, RHS_OE  out  1 each  operand valid
ADDR_LOAD_bar  in  1  address register load enable
ADDR_LOAD_SEL  in  SEL_W  AR load target
ADDR_LOAD_PAIR  in  1  0: load from ADDR_in; 1: load {GP[2k+1],GP[2k]} where k=MAIN_ASSERT_SEL[SEL_W-1:1]
ADDR_in  in  ADDR_W  address load data
ADDR_INC  in  1  step enable
ADDR_INC_SEL  in  SEL_W  AR step target
ADDR_DEC  in  1  step direction: 0 = +1, 1 = -1
ADDR_ASSERT_bar  in  1  ADDR read enable
ADDR_ASSERT_SEL  in  SEL_W  ADDR read select
ADDR_out  out  ADDR_W  address read data
ADDR_OE  out  1  ADDR_out valid
ADDR_WRAP  out  1  registered one-cycle pulse: last step wrapped

Behaviour:
- Reset: RST_bar low at a rising edge clears all GP registers, all ARs and ADDR_WRAP to 0 and overrides every load/step in that cycle. Read outputs are combinational from the cleared state.
- Reads: combinational, zero latency.
  - Port enabled (*_ASSERT_bar=0) and select < register count: *_out = selected register, *_OE = 1.
  - Otherwise: *_out = 0 and *_OE = 0.
  - The same register may be read on all ports at once.
- GP write: at the edge with MAIN_LOAD_bar=0 and MAIN_LOAD_SEL < N_GP, GP[sel] <= MAIN_in. Out-of-range select: no write.
- GP read-during-write: reads return the old value until the edge.
- AR load: at the edge with ADDR_LOAD_bar=0 and sel < N_AR.
  - Source is ADDR_in, or the GP pair when ADDR_LOAD_PAIR=1.
  - The pair uses pre-edge GP values, so a same-cycle GP write is not seen.
- AR step: at the edge with ADDR_INC=1 and sel < N_AR, AR[sel] <= AR[sel] +/- 1 modulo 2**ADDR_W.
- Wrap: ADDR_WRAP <= 1 for exactly the next cycle when a step goes all-ones -> 0 (inc) or 0 -> all-ones (dec); otherwise 0.
- Load and step on the same AR in the same cycle: load wins, no step, ADDR_WRAP=0. Load and step on different ARs: both take effect.
- Out-of-range selects on any port are ignored, with no side effects.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding. A read of GP[s] in the same cycle as an active write to GP[s] returns MAIN_in. A read of AR[s] during a load returns the load source. A read of AR[s] during a step returns the stepped value.
- Not defined: reads return pre-edge state as described above.

Decomposition:
- Shared package regfile_pkg holds the step-direction constants (STEP_INC=0, STEP_DEC=1) and a sel_valid(sel, count) helper function.
- One natural sub-module: addr_counter (ADDR_W-bit register with sync clear, load, +/-1 step, load-priority rule and wrap detect), instantiated N_AR times.
- GP storage and read muxes stay inline.

Test Plan:
- Reset: write GP0=0x5A, AR1=0x1234, then assert RST_bar=0 for one cycle -> every register reads 0 and ADDR_WRAP=0.
- Triple read: GP1=0x11, GP2=0x22; MAIN sel1, LHS sel2, RHS sel1 in the same cycle -> 0x11/0x22/0x11 with all OE=1. Select 5 with N_GP=4 -> out=0, OE=0.
- Increment wrap: AR0=0xFFFF, ADDR_INC=1, ADDR_DEC=0 -> AR0=0x0000 and ADDR_WRAP pulses high one cycle. Repeat with ADDR_DEC=1 from 0x0000 -> 0xFFFF with a wrap pulse.
- Load priority: AR2=0x0010; same cycle ADDR_LOAD_bar=0 (ADDR_in=0x8000) and ADDR_INC on AR2 -> AR2=0x8000, no wrap. Load AR2 while stepping AR3 -> both updated.
- Pair load: GP2=0x34, GP3=0x12, MAIN_ASSERT_SEL=2, ADDR_LOAD_PAIR=1 into AR1 -> AR1=0x1234. A same-cycle write GP2<=0xFF is not seen in AR1.
- Read-during-write: write GP0<=0x77 while MAIN reads GP0 (old 0x00) -> 0x00 without REGFILE_BYPASS_EN, 0x77 with it.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
// Holds the address-step direction encoding and the select range check.
package regfile_pkg;

  // Step direction as driven on ADDR_DEC.
  localparam logic STEP_INC = 1'b0;
  localparam logic STEP_DEC = 1'b1;

  // A select addresses a real register only when it is below the register count.
  function automatic logic sel_valid(input int unsigned sel, input int unsigned count);
    return (sel < count);
  endfunction

endpackage

// File: rtl/addr_counter.sv
// One address register: synchronous clear, load, +/-1 step and wrap detect.
// A load in the same cycle as a step wins; the step and its wrap are dropped.
// Optional macro REGFILE_BYPASS_EN: rd_value forwards the value being
// written this cycle instead of the stored value.
import regfile_pkg::*;

module addr_counter #(
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST_bar,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_data,
  input  logic              step_en,
  input  logic              step_dir,
  output logic [ADDR_W-1:0] rd_value,
  output logic              wrap_pulse
);

  logic [ADDR_W-1:0] count_reg;
  logic [ADDR_W-1:0] count_next;
  logic              wrap_reg;
  logic              wrap_next;

  // Next count and wrap flag; load has priority over step.
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (load_en) begin
      count_next = load_data;
    end else if (step_en) begin
      case (step_dir)
        STEP_INC: begin
          count_next = count_reg + ADDR_W'(1);
          wrap_next  = &count_reg;
        end
        STEP_DEC: begin
          count_next = count_reg - ADDR_W'(1);
          wrap_next  = (count_reg == '0);
        end
        default: begin
          count_next = count_reg;
          wrap_next  = 1'b0;
        end
      endcase
    end
  end

  // Count and wrap state; reset overrides any load or step in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign rd_value = count_next;
`else
  assign rd_value = count_reg;
`endif

  assign wrap_pulse = wrap_reg;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: N_GP data registers with one write and three
// read ports, plus N_AR address registers with load, +/-1 step, pair load
// from two GP registers, and a registered wrap pulse.
// Optional macro REGFILE_BYPASS_EN: reads forward same-cycle writes, loads
// and steps instead of returning the pre-edge state.
import regfile_pkg::*;

module regfile_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int N_GP   = 4,
  parameter int N_AR   = 4,
  parameter int SEL_W  = 3
) (
  input  logic              CLK,
  input  logic              RST_bar,
  input  logic              MAIN_LOAD_bar,
  input  logic [SEL_W-1:0]  MAIN_LOAD_SEL,
  input  logic [DATA_W-1:0] MAIN_in,
  input  logic              MAIN_ASSERT_bar,
  input  logic [SEL_W-1:0]  MAIN_ASSERT_SEL,
  output logic [DATA_W-1:0] MAIN_out,
  output logic              MAIN_OE,
  input  logic              LHS_ASSERT_bar,
  input  logic [SEL_W-1:0]  LHS_ASSERT_SEL,
  output logic [DATA_W-1:0] LHS_out,
  output logic              LHS_OE,
  input  logic              RHS_ASSERT_bar,
  input  logic [SEL_W-1:0]  RHS_ASSERT_SEL,
  output logic [DATA_W-1:0] RHS_out,
  output logic              RHS_OE,
  input  logic              ADDR_LOAD_bar,
  input  logic [SEL_W-1:0]  ADDR_LOAD_SEL,
  input  logic              ADDR_LOAD_PAIR,
  input  logic [ADDR_W-1:0] ADDR_in,
  input  logic              ADDR_INC,
  input  logic [SEL_W-1:0]  ADDR_INC_SEL,
  input  logic              ADDR_DEC,
  input  logic              ADDR_ASSERT_bar,
  input  logic [SEL_W-1:0]  ADDR_ASSERT_SEL,
  output logic [ADDR_W-1:0] ADDR_out,
  output logic              ADDR_OE,
  output logic              ADDR_WRAP
);

  // ---------------- GP registers ----------------
  logic [DATA_W-1:0] gp_reg [N_GP];
  logic [DATA_W-1:0] gp_rd  [N_GP];
  logic [N_GP-1:0]   gp_we;

  // Per-register write decode and read-visible value.
  for (genvar gi = 0; gi < N_GP; gi++) begin : g_gp
    assign gp_we[gi] = !MAIN_LOAD_bar && (MAIN_LOAD_SEL == SEL_W'(gi));
`ifdef REGFILE_BYPASS_EN
    assign gp_rd[gi] = gp_we[gi] ? MAIN_in : gp_reg[gi];
`else
    assign gp_rd[gi] = gp_reg[gi];
`endif
  end

  // GP storage; out-of-range write selects match no register and are dropped.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_GP; i++) begin
      if (!RST_bar) begin
        gp_reg[i] <= '0;
      end else if (gp_we[i]) begin
        gp_reg[i] <= MAIN_in;
      end
    end
  end

  // MAIN read port.
  always_comb begin
    MAIN_out = '0;
    MAIN_OE  = 1'b0;
    if (!MAIN_ASSERT_bar && sel_valid(32'(MAIN_ASSERT_SEL), N_GP)) begin
      MAIN_OE = 1'b1;
      for (int i = 0; i < N_GP; i++) begin
        if (MAIN_ASSERT_SEL == SEL_W'(i)) MAIN_out = gp_rd[i];
      end
    end
  end

  // LHS read port.
  always_comb begin
    LHS_out = '0;
    LHS_OE  = 1'b0;
    if (!LHS_ASSERT_bar && sel_valid(32'(LHS_ASSERT_SEL), N_GP)) begin
      LHS_OE = 1'b1;
      for (int i = 0; i < N_GP; i++) begin
        if (LHS_ASSERT_SEL == SEL_W'(i)) LHS_out = gp_rd[i];
      end
    end
  end

  // RHS read port.
  always_comb begin
    RHS_out = '0;
    RHS_OE  = 1'b0;
    if (!RHS_ASSERT_bar && sel_valid(32'(RHS_ASSERT_SEL), N_GP)) begin
      RHS_OE = 1'b1;
      for (int i = 0; i < N_GP; i++) begin
        if (RHS_ASSERT_SEL == SEL_W'(i)) RHS_out = gp_rd[i];
      end
    end
  end

  // ---------------- Pair source ----------------
  // {GP[2k+1], GP[2k]} with k = MAIN_ASSERT_SEL[SEL_W-1:1], always taken
  // from stored (pre-edge) values. Missing registers contribute zero.
  logic [ADDR_W-1:0] pair_word;

  if (ADDR_W == 2 * DATA_W) begin : g_pair
    logic [DATA_W-1:0] pair_lo;
    logic [DATA_W-1:0] pair_hi;

    // Pick the even/odd register of the selected pair.
    always_comb begin
      pair_lo = '0;
      pair_hi = '0;
      for (int i = 0; i < N_GP; i++) begin
        if (SEL_W'(i) == {MAIN_ASSERT_SEL[SEL_W-1:1], 1'b0}) pair_lo = gp_reg[i];
        if (SEL_W'(i) == {MAIN_ASSERT_SEL[SEL_W-1:1], 1'b1}) pair_hi = gp_reg[i];
      end
    end

    assign pair_word = {pair_hi, pair_lo};
  end else begin : g_no_pair
    // Pair load has no meaning unless the address is exactly two data words.
    assign pair_word = '0;
  end

  // ---------------- Address registers ----------------
  logic [ADDR_W-1:0] ar_src;
  logic [ADDR_W-1:0] ar_rd [N_AR];
  logic [N_AR-1:0]   ar_ld;
  logic [N_AR-1:0]   ar_st;
  logic [N_AR-1:0]   ar_wrap;

  assign ar_src = ADDR_LOAD_PAIR ? pair_word : ADDR_in;

  // One counter per address register; out-of-range selects match none.
  for (genvar gi = 0; gi < N_AR; gi++) begin : g_ar
    assign ar_ld[gi] = !ADDR_LOAD_bar && (ADDR_LOAD_SEL == SEL_W'(gi));
    assign ar_st[gi] = ADDR_INC && (ADDR_INC_SEL == SEL_W'(gi));

    addr_counter #(
      .ADDR_W(ADDR_W)
    ) u_ctr (
      .CLK        (CLK),
      .RST_bar    (RST_bar),
      .load_en    (ar_ld[gi]),
      .load_data  (ar_src),
      .step_en    (ar_st[gi]),
      .step_dir   (ADDR_DEC),
      .rd_value   (ar_rd[gi]),
      .wrap_pulse (ar_wrap[gi])
    );
  end

  // Only one register steps per cycle, so at most one wrap bit is set.
  assign ADDR_WRAP = |ar_wrap;

  // ADDR read port.
  always_comb begin
    ADDR_out = '0;
    ADDR_OE  = 1'b0;
    if (!ADDR_ASSERT_bar && sel_valid(32'(ADDR_ASSERT_SEL), N_AR)) begin
      ADDR_OE = 1'b1;
      for (int i = 0; i < N_AR; i++) begin
        if (ADDR_ASSERT_SEL == SEL_W'(i)) ADDR_out = ar_rd[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (default parameters).
// Expected read results are queued when a read is set up and popped when
// the outputs are sampled.
module tb_regfile_param;

  logic        CLK = 1'b0;
  logic        RST_bar;
  logic        MAIN_LOAD_bar;
  logic [2:0]  MAIN_LOAD_SEL;
  logic [7:0]  MAIN_in;
  logic        MAIN_ASSERT_bar;
  logic [2:0]  MAIN_ASSERT_SEL;
  logic [7:0]  MAIN_out;
  logic        MAIN_OE;
  logic        LHS_ASSERT_bar;
  logic [2:0]  LHS_ASSERT_SEL;
  logic [7:0]  LHS_out;
  logic        LHS_OE;
  logic        RHS_ASSERT_bar;
  logic [2:0]  RHS_ASSERT_SEL;
  logic [7:0]  RHS_out;
  logic        RHS_OE;
  logic        ADDR_LOAD_bar;
  logic [2:0]  ADDR_LOAD_SEL;
  logic        ADDR_LOAD_PAIR;
  logic [15:0] ADDR_in;
  logic        ADDR_INC;
  logic [2:0]  ADDR_INC_SEL;
  logic        ADDR_DEC;
  logic        ADDR_ASSERT_bar;
  logic [2:0]  ADDR_ASSERT_SEL;
  logic [15:0] ADDR_out;
  logic        ADDR_OE;
  logic        ADDR_WRAP;

  regfile_param dut (
    .CLK             (CLK),
    .RST_bar         (RST_bar),
    .MAIN_LOAD_bar   (MAIN_LOAD_bar),
    .MAIN_LOAD_SEL   (MAIN_LOAD_SEL),
    .MAIN_in         (MAIN_in),
    .MAIN_ASSERT_bar (MAIN_ASSERT_bar),
    .MAIN_ASSERT_SEL (MAIN_ASSERT_SEL),
    .MAIN_out        (MAIN_out),
    .MAIN_OE         (MAIN_OE),
    .LHS_ASSERT_bar  (LHS_ASSERT_bar),
    .LHS_ASSERT_SEL  (LHS_ASSERT_SEL),
    .LHS_out         (LHS_out),
    .LHS_OE          (LHS_OE),
    .RHS_ASSERT_bar  (RHS_ASSERT_bar),
    .RHS_ASSERT_SEL  (RHS_ASSERT_SEL),
    .RHS_out         (RHS_out),
    .RHS_OE          (RHS_OE),
    .ADDR_LOAD_bar   (ADDR_LOAD_bar),
    .ADDR_LOAD_SEL   (ADDR_LOAD_SEL),
    .ADDR_LOAD_PAIR  (ADDR_LOAD_PAIR),
    .ADDR_in         (ADDR_in),
    .ADDR_INC        (ADDR_INC),
    .ADDR_INC_SEL    (ADDR_INC_SEL),
    .ADDR_DEC        (ADDR_DEC),
    .ADDR_ASSERT_bar (ADDR_ASSERT_bar),
    .ADDR_ASSERT_SEL (ADDR_ASSERT_SEL),
    .ADDR_out        (ADDR_out),
    .ADDR_OE         (ADDR_OE),
    .ADDR_WRAP       (ADDR_WRAP)
  );

  always #5 CLK = ~CLK;

  int total_cnt = 0;
  int bad_cnt   = 0;

  string       tag_q [$];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    MAIN_LOAD_bar   = 1'b1; MAIN_LOAD_SEL   = 3'd0; MAIN_in = 8'h00;
    MAIN_ASSERT_bar = 1'b1; MAIN_ASSERT_SEL = 3'd0;
    LHS_ASSERT_bar  = 1'b1; LHS_ASSERT_SEL  = 3'd0;
    RHS_ASSERT_bar  = 1'b1; RHS_ASSERT_SEL  = 3'd0;
    ADDR_LOAD_bar   = 1'b1; ADDR_LOAD_SEL   = 3'd0; ADDR_LOAD_PAIR = 1'b0; ADDR_in = 16'h0;
    ADDR_INC        = 1'b0; ADDR_INC_SEL    = 3'd0; ADDR_DEC = 1'b0;
    ADDR_ASSERT_bar = 1'b1; ADDR_ASSERT_SEL = 3'd0;
  endtask

  // Set up all four read ports, queue expectations, then sample after settling.
  task automatic rd_full(input string tag,
                         input logic mb, input logic [2:0] ms,
                         input logic lb, input logic [2:0] ls,
                         input logic rb, input logic [2:0] rs,
                         input logic ab, input logic [2:0] as,
                         input logic [7:0] em, input logic emo,
                         input logic [7:0] el, input logic elo,
                         input logic [7:0] er, input logic ero,
                         input logic [15:0] ea, input logic eao,
                         input logic ew);
    MAIN_ASSERT_bar = mb; MAIN_ASSERT_SEL = ms;
    LHS_ASSERT_bar  = lb; LHS_ASSERT_SEL  = ls;
    RHS_ASSERT_bar  = rb; RHS_ASSERT_SEL  = rs;
    ADDR_ASSERT_bar = ab; ADDR_ASSERT_SEL = as;
    sb_push({tag, ".main"}, 32'(em));  sb_push({tag, ".main_oe"}, 32'(emo));
    sb_push({tag, ".lhs"},  32'(el));  sb_push({tag, ".lhs_oe"},  32'(elo));
    sb_push({tag, ".rhs"},  32'(er));  sb_push({tag, ".rhs_oe"},  32'(ero));
    sb_push({tag, ".addr"}, 32'(ea));  sb_push({tag, ".addr_oe"}, 32'(eao));
    sb_push({tag, ".wrap"}, 32'(ew));
    #1;
    sb_pop(32'(MAIN_out)); sb_pop(32'(MAIN_OE));
    sb_pop(32'(LHS_out));  sb_pop(32'(LHS_OE));
    sb_pop(32'(RHS_out));  sb_pop(32'(RHS_OE));
    sb_pop(32'(ADDR_out)); sb_pop(32'(ADDR_OE));
    sb_pop(32'(ADDR_WRAP));
  endtask

  // MAIN and ADDR reads only; LHS/RHS disabled and expected idle.
  task automatic rd(input string tag, input logic [2:0] gs, input logic [2:0] as,
                    input logic [7:0] eg, input logic [15:0] ea, input logic ew);
    rd_full(tag, 1'b0, gs, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, as,
            eg, (gs < 3'd4), 8'h00, 1'b0, 8'h00, 1'b0, ea, (as < 3'd4), ew);
  endtask

  task automatic wr_gp(input logic [2:0] s, input logic [7:0] d);
    idle();
    MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = s; MAIN_in = d;
    tick();
    idle();
  endtask

  task automatic ld_ar(input logic [2:0] s, input logic [15:0] d);
    idle();
    ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = s; ADDR_in = d;
    tick();
    idle();
  endtask

  task automatic step_ar(input logic [2:0] s, input logic dec);
    idle();
    ADDR_INC = 1'b1; ADDR_INC_SEL = s; ADDR_DEC = dec;
    tick();
    idle();
  endtask

  initial begin
    idle();
    RST_bar = 1'b0;
    tick();
    tick();
    RST_bar = 1'b1;

    // Reset state.
    rd("rst_init", 3'd0, 3'd0, 8'h00, 16'h0000, 1'b0);

    // Reset clears written state and overrides a same-cycle write.
    wr_gp(3'd0, 8'h5A);
    ld_ar(3'd1, 16'h1234);
    rd("pre_rst", 3'd0, 3'd1, 8'h5A, 16'h1234, 1'b0);
    MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd1; MAIN_in = 8'h99;
    ADDR_INC = 1'b1; ADDR_INC_SEL = 3'd2;
    RST_bar = 1'b0;
    tick();
    RST_bar = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) begin
      rd($sformatf("post_rst%0d", i), 3'(i), 3'(i), 8'h00, 16'h0000, 1'b0);
    end

    // Triple read plus out-of-range / disabled ports.
    wr_gp(3'd1, 8'h11);
    wr_gp(3'd2, 8'h22);
    rd_full("triple", 1'b0, 3'd1, 1'b0, 3'd2, 1'b0, 3'd1, 1'b1, 3'd0,
            8'h11, 1'b1, 8'h22, 1'b1, 8'h11, 1'b1, 16'h0, 1'b0, 1'b0);
    rd_full("oob_rd", 1'b0, 3'd5, 1'b1, 3'd1, 1'b0, 3'd4, 1'b0, 3'd5,
            8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 1'b0);

    // Out-of-range writes, loads and steps change nothing.
    idle();
    MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd5; MAIN_in = 8'hEE;
    ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd6; ADDR_in = 16'hBEEF;
    ADDR_INC = 1'b1; ADDR_INC_SEL = 3'd7;
    tick();
    idle();
    rd("oob_wr0", 3'd0, 3'd0, 8'h00, 16'h0000, 1'b0);
    rd("oob_wr1", 3'd1, 3'd1, 8'h11, 16'h0000, 1'b0);
    rd("oob_wr2", 3'd2, 3'd2, 8'h22, 16'h0000, 1'b0);
    rd("oob_wr3", 3'd3, 3'd3, 8'h00, 16'h0000, 1'b0);

    // Increment wrap, then decrement wrap, each pulsing for one cycle.
    ld_ar(3'd0, 16'hFFFF);
    rd("inc_pre", 3'd0, 3'd0, 8'h00, 16'hFFFF, 1'b0);
    step_ar(3'd0, 1'b0);
    rd("inc_wrap", 3'd0, 3'd0, 8'h00, 16'h0000, 1'b1);
    tick();
    rd("inc_wrap_end", 3'd0, 3'd0, 8'h00, 16'h0000, 1'b0);
    step_ar(3'd0, 1'b1);
    rd("dec_wrap", 3'd0, 3'd0, 8'h00, 16'hFFFF, 1'b1);
    tick();
    rd("dec_wrap_end", 3'd0, 3'd0, 8'h00, 16'hFFFF, 1'b0);
    step_ar(3'd0, 1'b1);
    rd("dec_plain", 3'd0, 3'd0, 8'h00, 16'hFFFE, 1'b0);
    ld_ar(3'd0, 16'h0010);
    step_ar(3'd0, 1'b0);
    rd("inc_plain", 3'd0, 3'd0, 8'h00, 16'h0011, 1'b0);

    // Load beats step on the same register (step from all-ones would wrap).
    ld_ar(3'd2, 16'hFFFF);
    idle();
    ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd2; ADDR_in = 16'h8000;
    ADDR_INC = 1'b1; ADDR_INC_SEL = 3'd2; ADDR_DEC = 1'b0;
    tick();
    idle();
    rd("ld_prio", 3'd0, 3'd2, 8'h00, 16'h8000, 1'b0);

    // Load and step on different registers both take effect.
    idle();
    ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd2; ADDR_in = 16'h1111;
    ADDR_INC = 1'b1; ADDR_INC_SEL = 3'd3; ADDR_DEC = 1'b0;
    tick();
    idle();
    rd("ld_ar2", 3'd0, 3'd2, 8'h00, 16'h1111, 1'b0);
    rd("step_ar3", 3'd0, 3'd3, 8'h00, 16'h0001, 1'b0);

    // Pair load uses pre-edge GP values.
    wr_gp(3'd2, 8'h34);
    wr_gp(3'd3, 8'h12);
    idle();
    MAIN_ASSERT_SEL = 3'd2;
    ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd1; ADDR_LOAD_PAIR = 1'b1; ADDR_in = 16'hAAAA;
    MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd2; MAIN_in = 8'hFF;
    tick();
    idle();
    rd("pair_ar1", 3'd2, 3'd1, 8'hFF, 16'h1234, 1'b0);
    idle();
    MAIN_ASSERT_SEL = 3'd1;
    ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd3; ADDR_LOAD_PAIR = 1'b1;
    tick();
    idle();
    rd("pair_lo", 3'd1, 3'd3, 8'h11, 16'h1100, 1'b0);

    // Read during write on GP0.
    idle();
    MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd0; MAIN_in = 8'h77;
`ifdef REGFILE_BYPASS_EN
    rd("rdw", 3'd0, 3'd0, 8'h77, 16'h0011, 1'b0);
`else
    rd("rdw", 3'd0, 3'd0, 8'h00, 16'h0011, 1'b0);
`endif
    tick();
    idle();
    rd("rdw_after", 3'd0, 3'd0, 8'h77, 16'h0011, 1'b0);

    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
